// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the 16-bit CPU: one instruction in flight,
// FETCH/DECODE/EXEC/MEM/WB with a shared memory port guarded by a wait timeout.
module cpu_ctrl_seq #(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           alu_zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           addr_sel,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_src,
  output logic           alu_src,
  output logic [OPW-1:0] alu_op,
  output logic           reg_we,
  output logic           wb_sel,
  output logic           instr_done,
  output logic           halted,
  output logic           fault,
  output logic [2:0]     state_dbg
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_SW   = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);
  localparam logic [OPW-1:0] ALU_ADD = OPW'(0);
  localparam logic [OPW-1:0] ALU_SUB = OPW'(1);

  // Counter only needs to reach TIMEOUT-1: the wait that would make it TIMEOUT is the fault.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic            run_q;
  logic            tmo;
  logic            is_lw, is_sw;

  assign is_lw = (opcode == OP_LW);
  assign is_sw = (opcode == OP_SW);
  assign tmo   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1)) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      run_q   <= run;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    fault_d    = fault_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op  = funct;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            alu_op     = ALU_SUB;
            pc_we      = alu_zero;
            pc_src     = alu_zero ? 2'd1 : 2'd0;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JMP: begin
            pc_we      = 1'b1;
            pc_src     = 2'd2;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_HALT: begin
            instr_done = 1'b1;
            state_d    = S_HALT;
          end
          default: begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_sw;
        alu_src  = 1'b1;
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_sel     = is_lw;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        // Resume needs a fresh 0->1 on run; a level held since before HALT is ignored.
        if (run && !run_q) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fault     = fault_q;
  assign state_dbg = state_q;

endmodule
